// File: rtl/scaler_lut_step.sv
// Per-axis scaler step generator: source index, phase and advance per output beat.
// Optional build macro: SCALER_LUT_ROUND_EN (round phase to nearest instead of truncate).
module scaler_lut_step #(
    parameter int IMG_MAX          = 1920,
    parameter int IMG_BITWIDTH     = $clog2(IMG_MAX + 1),
    parameter int PHASE_NUM        = 4,
    parameter int PHASE_BITWIDTH   = $clog2(PHASE_NUM + 1) - 1,
    parameter int SF_BITWIDTH      = 24,
    parameter int SF_INT_BITWIDTH  = 4,
    parameter int SF_FRAC_BITWIDTH = 20,
    parameter int ADV_BITWIDTH     = SF_INT_BITWIDTH + 1
) (
    input  logic                      core_clk,
    input  logic                      core_rst,
    input  logic [IMG_BITWIDTH-1:0]   core_arg_img_src,
    input  logic [IMG_BITWIDTH-1:0]   core_arg_img_des,
    input  logic [SF_BITWIDTH-1:0]    core_arg_sf,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      m_axis_valid,
    input  logic                      m_axis_ready,
    output logic [IMG_BITWIDTH-1:0]   m_axis_src_idx,
    output logic [PHASE_BITWIDTH-1:0] m_axis_phase,
    output logic [ADV_BITWIDTH-1:0]   m_axis_adv,
    output logic                      m_axis_repeat,
    output logic                      m_axis_stride,
    output logic                      m_axis_last
);

    localparam int ACC_W = IMG_BITWIDTH + SF_FRAC_BITWIDTH + 1;
    localparam int ADD_W = ACC_W + 1;
    localparam int INT_W = ADD_W - SF_FRAC_BITWIDTH;
    localparam int IDX_W = IMG_BITWIDTH + 1;
    localparam int LOW_W = SF_FRAC_BITWIDTH - PHASE_BITWIDTH;
`ifdef SCALER_LUT_ROUND_EN
    localparam logic [ADD_W-1:0] RND = ADD_W'(1) << (LOW_W - 1);
`else
    localparam logic [ADD_W-1:0] RND = '0;
`endif
    localparam logic [IDX_W-1:0] ADV_SAT = IDX_W'((1 << ADV_BITWIDTH) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OUT,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IMG_BITWIDTH-1:0] src_r;
    logic [IMG_BITWIDTH-1:0] des_r;
    logic [SF_BITWIDTH-1:0]  sf_r;
    logic [ACC_W-1:0]        acc;
    logic [IDX_W-1:0]        prev_idx;
    logic [IMG_BITWIDTH-1:0] beat;

    logic [ACC_W-1:0]          addr;
    logic [IDX_W-1:0]          prev_sel;
    logic [ADD_W-1:0]          rnd;
    logic [INT_W-1:0]          int_part;
    logic                      clamp;
    logic [IMG_BITWIDTH-1:0]   nxt_idx;
    logic [PHASE_BITWIDTH-1:0] nxt_phase;
    logic [IDX_W-1:0]          diff;
    logic [ADV_BITWIDTH-1:0]   nxt_adv;
    logic [IMG_BITWIDTH-1:0]   nxt_beat;
    logic                      nxt_last;
    logic                      hs;
    logic                      unused_low;

    assign hs   = m_axis_valid & m_axis_ready;
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // LOAD describes acc itself; a handshake describes the next address acc+sf
    always_comb begin
        addr      = acc;
        prev_sel  = prev_idx;
        nxt_beat  = '0;
        if (state != ST_LOAD) begin
            addr     = acc + ACC_W'(sf_r);
            prev_sel = {1'b0, m_axis_src_idx};
            nxt_beat = beat + 1'b1;
        end
        rnd       = {1'b0, addr} + RND;
        int_part  = rnd[ADD_W-1:SF_FRAC_BITWIDTH];
        clamp     = int_part >= INT_W'(src_r);
        nxt_idx   = int_part[IMG_BITWIDTH-1:0];
        nxt_phase = rnd[SF_FRAC_BITWIDTH-1 -: PHASE_BITWIDTH];
        if (clamp) begin
            nxt_idx   = src_r - 1'b1;
            nxt_phase = '0;
        end
        diff = {1'b0, nxt_idx} - prev_sel;
        if (diff > ADV_SAT) begin
            nxt_adv = ADV_SAT[ADV_BITWIDTH-1:0];
        end else begin
            nxt_adv = diff[ADV_BITWIDTH-1:0];
        end
        nxt_last = (nxt_beat == des_r - 1'b1);
    end

    assign unused_low = ^rnd[LOW_W-1:0];

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = (des_r == '0) ? ST_DONE : ST_OUT;
            ST_OUT:  if (hs && m_axis_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state          <= ST_IDLE;
            src_r          <= '0;
            des_r          <= '0;
            sf_r           <= '0;
            acc            <= '0;
            prev_idx       <= '1;
            beat           <= '0;
            m_axis_valid   <= 1'b0;
            m_axis_src_idx <= '0;
            m_axis_phase   <= '0;
            m_axis_adv     <= '0;
            m_axis_repeat  <= 1'b0;
            m_axis_stride  <= 1'b0;
            m_axis_last    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_r    <= core_arg_img_src;
                        des_r    <= core_arg_img_des;
                        sf_r     <= core_arg_sf;
                        acc      <= '0;
                        prev_idx <= '1;
                        beat     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (des_r != '0) begin
                        m_axis_valid   <= 1'b1;
                        m_axis_src_idx <= nxt_idx;
                        m_axis_phase   <= nxt_phase;
                        m_axis_adv     <= nxt_adv;
                        m_axis_repeat  <= (nxt_adv == '0);
                        m_axis_stride  <= (nxt_adv > ADV_BITWIDTH'(1));
                        m_axis_last    <= (des_r == IMG_BITWIDTH'(1));
                    end
                end
                ST_OUT: begin
                    if (hs) begin
                        if (m_axis_last) begin
                            m_axis_valid <= 1'b0;
                        end else begin
                            acc            <= addr;
                            prev_idx       <= {1'b0, m_axis_src_idx};
                            beat           <= nxt_beat;
                            m_axis_src_idx <= nxt_idx;
                            m_axis_phase   <= nxt_phase;
                            m_axis_adv     <= nxt_adv;
                            m_axis_repeat  <= (nxt_adv == '0);
                            m_axis_stride  <= (nxt_adv > ADV_BITWIDTH'(1));
                            m_axis_last    <= nxt_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scaler_lut_step.sv
// Scoreboard bench for scaler_lut_step: directed frames, backpressure and control corners.
module tb_scaler_lut_step;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic [10:0] core_arg_img_src;
    logic [10:0] core_arg_img_des;
    logic [23:0] core_arg_sf;
    logic        start;
    logic        busy;
    logic        done;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [10:0] m_axis_src_idx;
    logic [1:0]  m_axis_phase;
    logic [4:0]  m_axis_adv;
    logic        m_axis_repeat;
    logic        m_axis_stride;
    logic        m_axis_last;

    scaler_lut_step dut (
        .core_clk(core_clk),
        .core_rst(core_rst),
        .core_arg_img_src(core_arg_img_src),
        .core_arg_img_des(core_arg_img_des),
        .core_arg_sf(core_arg_sf),
        .start(start),
        .busy(busy),
        .done(done),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_src_idx(m_axis_src_idx),
        .m_axis_phase(m_axis_phase),
        .m_axis_adv(m_axis_adv),
        .m_axis_repeat(m_axis_repeat),
        .m_axis_stride(m_axis_stride),
        .m_axis_last(m_axis_last)
    );

    typedef struct packed {
        logic [10:0] idx;
        logic [1:0]  ph;
        logic [4:0]  adv;
        logic        rep;
        logic        str;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cyc = -10;
    int first_valid_cyc = -1;
    int valid_cnt = 0;
    int ready_mode = 0;
    int k_cyc = 0;
    logic [15:0] pat = 16'b1001_0110_1100_1001;
    logic stalled_prev = 1'b0;
    beat_t held;

    always #5 core_clk = ~core_clk;

    initial forever begin
        @(posedge core_clk);
        cyc++;
    end

    initial begin
        m_axis_ready = 1'b1;
        forever begin
            @(posedge core_clk);
            #1;
            case (ready_mode)
                0: m_axis_ready = 1'b1;
                1: m_axis_ready = pat[cyc % 16];
                default: m_axis_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic beat_t cur_beat();
        return {m_axis_src_idx, m_axis_phase, m_axis_adv,
                m_axis_repeat, m_axis_stride, m_axis_last};
    endfunction

    task automatic push(input int idx, input int ph, input int adv, input bit last);
        beat_t e;
        e.idx  = 11'(idx);
        e.ph   = 2'(ph);
        e.adv  = 5'(adv);
        e.rep  = (adv == 0);
        e.str  = (adv > 1);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // monitor: pops the scoreboard on every accepted beat
    initial forever begin
        beat_t c;
        beat_t e;
        @(negedge core_clk);
        if (core_rst) begin
            stalled_prev = 1'b0;
        end else begin
            c = cur_beat();
            if (stalled_prev && m_axis_valid)
                chk("stall_hold", int'(c), int'(held));
            stalled_prev = m_axis_valid & ~m_axis_ready;
            held = c;
            if (m_axis_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", int'(c), int'(e));
                end
                if (m_axis_last) hs_cyc = cyc;
            end
        end
    end

    task automatic begin_frame(input int src, input int des, input int sf);
        valid_cnt = 0;
        first_valid_cyc = -1;
        @(posedge core_clk);
        #1;
        core_arg_img_src = 11'(src);
        core_arg_img_des = 11'(des);
        core_arg_sf = 24'(sf);
        start = 1'b1;
        @(posedge core_clk);
        #1;
        start = 1'b0;
        @(negedge core_clk);
        k_cyc = cyc;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic finish_frame(input int des, input bit full_rate);
        int dcyc;
        dcyc = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge core_clk);
        end
        chk("done_seen", int'(dcyc >= 0), 1);
        chk("done_after_last", dcyc, hs_cyc + 1);
        chk("first_valid", first_valid_cyc, k_cyc + 1);
        chk("queue_empty", exp_q.size(), 0);
        if (full_rate) chk("valid_cycles", valid_cnt, des);
        @(negedge core_clk);
        chk("done_pulse_len", int'(done), 0);
        chk("busy_end", int'(busy), 0);
    endtask

    task automatic push_down();
        push(0, 0, 1, 0);
        push(3, 0, 3, 0);
        push(6, 0, 3, 0);
        push(9, 0, 3, 1);
    endtask

    int up_idx[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    int up_adv[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
`ifdef SCALER_LUT_ROUND_EN
    int up_ph[12]  = '{0, 1, 3, 0, 1, 3, 0, 1, 3, 0, 1, 3};
`else
    int up_ph[12]  = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        core_rst = 1'b1;
        start = 1'b0;
        core_arg_img_src = '0;
        core_arg_img_des = '0;
        core_arg_sf = '0;
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_valid", int'(m_axis_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_outputs", int'(cur_beat()), 0);
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;

        ready_mode = 0;
        push_down();
        begin_frame(12, 4, 24'h300000);
        finish_frame(4, 1);

        for (int i = 0; i < 12; i++) push(up_idx[i], up_ph[i], up_adv[i], i == 11);
        begin_frame(4, 12, 24'h055556);
        finish_frame(12, 1);

        for (int i = 0; i < 4; i++) push(i, 0, 1, 0);
        push(3, 0, 0, 1);
        begin_frame(4, 5, 24'h100000);
        finish_frame(5, 1);

        ready_mode = 1;
        push_down();
        begin_frame(12, 4, 24'h300000);
        finish_frame(4, 0);
        ready_mode = 0;

        begin_frame(4, 0, 24'h100000);
        @(negedge core_clk);
        chk("des0_done", int'(done), 1);
        chk("des0_valid", valid_cnt, 0);
        @(negedge core_clk);
        chk("des0_done_low", int'(done), 0);
        chk("des0_busy_end", int'(busy), 0);

        ready_mode = 1;
        push_down();
        begin_frame(12, 4, 24'h300000);
        @(posedge core_clk);
        #1;
        core_arg_img_src = 11'd4;
        core_arg_img_des = 11'd2;
        core_arg_sf = 24'h100000;
        start = 1'b1;
        @(posedge core_clk);
        #1;
        start = 1'b0;
        finish_frame(4, 0);
        ready_mode = 0;

        ready_mode = 2;
        begin_frame(12, 4, 24'h300000);
        repeat (3) @(negedge core_clk);
        chk("pre_rst_valid", int'(m_axis_valid), 1);
        #2;
        core_rst = 1'b1;
        #1;
        chk("midrst_valid", int'(m_axis_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(posedge core_clk);
        #1;
        core_rst = 1'b0;
        ready_mode = 0;
        push_down();
        begin_frame(12, 4, 24'h300000);
        finish_frame(4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
